// File: rtl/rr_xbar.sv
// rr_xbar: NumIn x NumOut request/response crossbar, one round-robin arbiter per output port,
// combinational request path and a RespLat-deep response pipeline per input.
module rr_xbar #(
  parameter int NumIn         = 4,
  parameter int NumOut        = 4,
  parameter int ReqDataWidth  = 32,
  parameter int RespDataWidth = 32,
  parameter int RespLat       = 1,
  parameter bit WriteRespOn   = 1'b1,
  parameter bit ExtPrio       = 1'b0,
  localparam int AW = NumOut > 1 ? $clog2(NumOut) : 1,
  localparam int PW = NumIn > 1 ? $clog2(NumIn) : 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NumOut-1:0][PW-1:0]              rr_i,
  input  logic [NumIn-1:0]                       req_i,
  input  logic [NumIn-1:0][AW-1:0]               add_i,
  input  logic [NumIn-1:0]                       wen_i,
  input  logic [NumIn-1:0][ReqDataWidth-1:0]     wdata_i,
  output logic [NumIn-1:0]                       gnt_o,
  output logic [NumIn-1:0]                       vld_o,
  output logic [NumIn-1:0][RespDataWidth-1:0]    rdata_o,
  output logic [NumOut-1:0]                      req_o,
  input  logic [NumOut-1:0]                      gnt_i,
  output logic [NumOut-1:0][ReqDataWidth-1:0]    wdata_o,
  input  logic [NumOut-1:0][RespDataWidth-1:0]   rdata_i
);
  logic [NumOut-1:0][NumIn-1:0] req_m;
  logic [NumOut-1:0][PW-1:0] sel, prio, ptr_q;
  logic [NumIn-1:0] vld_d;
  logic [NumIn-1:0][AW-1:0] add_d;
  logic [RespLat-1:0][NumIn-1:0] vld_q;
  logic [RespLat-1:0][NumIn-1:0][AW-1:0] add_q;
  always_comb begin
    for (int o = 0; o < NumOut; o++)
      for (int i = 0; i < NumIn; i++)
        req_m[o][i] = req_i[i] && (NumOut == 1 || add_i[i] == AW'(o));
  end
  // First requester at or above the priority index wins; otherwise wrap to the lowest requester.
  always_comb begin
    logic hit;
    logic [PW-1:0] hi, lo;
    for (int o = 0; o < NumOut; o++) begin
      prio[o] = ExtPrio ? rr_i[o] : ptr_q[o];
      hit = 1'b0;
      hi = '0;
      lo = '0;
      for (int i = NumIn - 1; i >= 0; i--) begin
        if (req_m[o][i] && PW'(i) >= prio[o]) begin
          hit = 1'b1;
          hi = PW'(i);
        end
        if (req_m[o][i]) lo = PW'(i);
      end
      sel[o] = hit ? hi : lo;
      req_o[o] = |req_m[o];
      wdata_o[o] = req_o[o] ? wdata_i[sel[o]] : '0;
    end
  end
  always_comb begin
    for (int i = 0; i < NumIn; i++) begin
      gnt_o[i] = 1'b0;
      for (int o = 0; o < NumOut; o++)
        gnt_o[i] = gnt_o[i] | (req_m[o][i] && gnt_i[o] && sel[o] == PW'(i));
      vld_d[i] = gnt_o[i] && (!wen_i[i] || WriteRespOn);
      add_d[i] = NumOut == 1 ? '0 : add_i[i];
      vld_o[i] = vld_q[RespLat-1][i];
      rdata_o[i] = int'(add_q[RespLat-1][i]) < NumOut ? rdata_i[add_q[RespLat-1][i]] : '0;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      vld_q <= '0;
      add_q <= '0;
    end else begin
      for (int o = 0; o < NumOut; o++)
        if (req_o[o] && gnt_i[o]) ptr_q[o] <= sel[o] == PW'(NumIn - 1) ? '0 : sel[o] + 1'b1;
      for (int s = RespLat - 1; s > 0; s--) begin
        vld_q[s] <= vld_q[s-1];
        add_q[s] <= add_q[s-1];
      end
      vld_q[0] <= vld_d;
      add_q[0] <= add_d;
    end
  end
endmodule

// File: tb/tb_rr_xbar.sv
// tb_rr_xbar: two crossbar configurations driven by shared directed and random stimulus,
// checked against a cyclic-scan arbiter model and a due-cycle response list.
module tb_rr_xbar;
  localparam int N = 4;
  localparam int EP [2] = '{0, 1};
  localparam int WR [2] = '{1, 0};
  localparam int RL [2] = '{1, 3};
  typedef struct {int due; int d; int i; int a;} pend_t;
  logic clk_i = 1'b0;
  logic rst_ni;
  logic [N-1:0][1:0] rr_i;
  logic [N-1:0] req_i, wen_i, gnt_i;
  logic [N-1:0][1:0] add_i;
  logic [N-1:0][31:0] wdata_i, rdata_i;
  logic [N-1:0] gnt_o [2];
  logic [N-1:0] vld_o [2];
  logic [N-1:0] req_o [2];
  logic [N-1:0][31:0] rdata_o [2];
  logic [N-1:0][31:0] wdata_o [2];
  int total = 0, bad = 0, cyc = 0;
  int ptr_m [2][N];
  int win [2][N];
  logic [N-1:0] eg [2];
  pend_t pend [$];
  always #5 clk_i = ~clk_i;
  rr_xbar #(.ExtPrio(1'b0), .WriteRespOn(1'b1), .RespLat(1)) dut0 (
    .clk_i(clk_i), .rst_ni(rst_ni), .rr_i(rr_i), .req_i(req_i), .add_i(add_i), .wen_i(wen_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o[0]), .vld_o(vld_o[0]), .rdata_o(rdata_o[0]), .req_o(req_o[0]),
    .gnt_i(gnt_i), .wdata_o(wdata_o[0]), .rdata_i(rdata_i));
  rr_xbar #(.ExtPrio(1'b1), .WriteRespOn(1'b0), .RespLat(3)) dut1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .rr_i(rr_i), .req_i(req_i), .add_i(add_i), .wen_i(wen_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o[1]), .vld_o(vld_o[1]), .rdata_o(rdata_o[1]), .req_o(req_o[1]),
    .gnt_i(gnt_i), .wdata_o(wdata_o[1]), .rdata_i(rdata_i));
  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s dut%0d cyc=%0d observed=%h expected=%h", tag, d, cyc, obs, exp);
    end
  endtask
  function automatic int winner(input int d, input int o);
    int p = EP[d] ? int'(rr_i[o]) : ptr_m[d][o];
    for (int k = 0; k < N; k++) begin
      int i = (p + k) % N;
      if (req_i[i] && int'(add_i[i]) == o) return i;
    end
    return -1;
  endfunction
  task automatic check();
    for (int d = 0; d < 2; d++) begin
      logic [N-1:0] er = '0, ev = '0;
      logic [31:0] erd [N];
      eg[d] = '0;
      for (int o = 0; o < N; o++) begin
        win[d][o] = winner(d, o);
        er[o] = win[d][o] >= 0;
        chk("wdata_o", d, wdata_o[d][o], win[d][o] >= 0 ? wdata_i[win[d][o]] : 32'h0);
      end
      for (int i = 0; i < N; i++) begin
        eg[d][i] = req_i[i] && win[d][add_i[i]] == i && gnt_i[add_i[i]];
        erd[i] = '0;
      end
      foreach (pend[k])
        if (pend[k].d == d && pend[k].due == cyc) begin
          ev[pend[k].i] = 1'b1;
          erd[pend[k].i] = rdata_i[pend[k].a];
        end
      chk("gnt_o", d, gnt_o[d], eg[d]);
      chk("req_o", d, req_o[d], er);
      chk("vld_o", d, vld_o[d], ev);
      for (int i = 0; i < N; i++)
        if (ev[i]) chk("rdata_o", d, rdata_o[d][i], erd[i]);
    end
  endtask
  task automatic step();
    for (int i = 0; i < N; i++) begin
      wdata_i[i] = $urandom;
      rdata_i[i] = $urandom;
    end
    #1;
    check();
    @(posedge clk_i);
    if (rst_ni) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < N; i++)
          if (eg[d][i] && (!wen_i[i] || WR[d] != 0))
            pend.push_back('{cyc + RL[d], d, i, int'(add_i[i])});
        for (int o = 0; o < N; o++)
          if (EP[d] == 0 && win[d][o] >= 0 && gnt_i[o]) ptr_m[d][o] = (win[d][o] + 1) % N;
      end
    end
    cyc++;
    for (int k = pend.size() - 1; k >= 0; k--)
      if (pend[k].due < cyc) pend.delete(k);
    #1;
  endtask
  task automatic set(input logic [3:0] r, input logic [7:0] a, input logic [3:0] w, input logic [3:0] g);
    req_i = r;
    add_i = a;
    wen_i = w;
    gnt_i = g;
  endtask
  task automatic do_reset();
    rst_ni = 1'b0;
    pend.delete();
    for (int d = 0; d < 2; d++)
      for (int o = 0; o < N; o++) ptr_m[d][o] = 0;
  endtask
  initial begin
    rr_i = '0;
    set(4'h0, 8'h00, 4'h0, 4'h0);
    do_reset();
    step();
    step();
    rst_ni = 1'b1;
    set(4'b0011, {2'd0, 2'd0, 2'd3, 2'd2}, 4'h0, 4'hf);
    step();
    set(4'h0, 8'h00, 4'h0, 4'hf);
    step();
    set(4'hf, {2'd1, 2'd1, 2'd1, 2'd1}, 4'h0, 4'hf);
    repeat (5) step();
    rr_i[0] = 2'd2;
    set(4'b1010, 8'h00, 4'h0, 4'hf);
    step();
    rr_i[0] = 2'd0;
    step();
    set(4'b0001, 8'h00, 4'h0, 4'he);
    step();
    set(4'b0001, 8'h00, 4'h0, 4'hf);
    step();
    set(4'h0, 8'h00, 4'h0, 4'hf);
    repeat (3) step();
    set(4'b0001, 8'h00, 4'h1, 4'hf);
    step();
    set(4'b0001, 8'h00, 4'h0, 4'hf);
    step();
    set(4'h0, 8'h00, 4'h0, 4'hf);
    repeat (4) step();
    set(4'b0100, {2'd0, 2'd3, 2'd0, 2'd0}, 4'h0, 4'hf);
    step();
    set(4'h0, 8'h00, 4'h0, 4'hf);
    do_reset();
    step();
    rst_ni = 1'b1;
    repeat (4) step();
    for (int n = 0; n < 400; n++) begin
      set(4'($urandom), 8'($urandom), 4'($urandom), 4'($urandom | $urandom));
      for (int o = 0; o < N; o++) rr_i[o] = 2'($urandom);
      if ($urandom_range(0, 49) == 0) do_reset();
      else rst_ni = 1'b1;
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
